flags_unit: RTL

- Architectural status-flag holder; the consumer side of the ALU status path.
- Owns the committed CF/PF/ZF/SF/OF register and drives it back to the ALU as `status_in`.
- Accepts flag writebacks from the execute stage, applies CLC/STC/CMC/flag loads, and answers x86 condition-code queries for Jcc/SETcc/CMOVcc.
- Tracks in-flight flag-writing ALU ops so that condition queries never observe stale flags.

---
 rtl/flags_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : flags_unit
// Purpose  : Committed CF/PF/ZF/SF/OF holder with flag ops, masked writeback,
//            in-flight flag-writer tracking and x86 condition-code evaluation.
// Revision : 1.0
// ============================================================================
module flags_unit #(
  parameter int MAX_PENDING = 3,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [4:0]        wb_mask,
  input  logic [4:0]        wb_status,
  input  logic              fop_valid,
  output logic              fop_ready,
  input  logic [1:0]        fop_code,
  input  logic [4:0]        fop_load,
  input  logic              cc_valid,
  output logic              cc_ready,
  input  logic [3:0]        cc_code,
  output logic              cc_resp_valid,
  output logic              cc_taken,
  output logic [4:0]        status_out,
  output logic [PEND_W-1:0] pending,
  output logic              proto_err
);

  localparam int c_CF = 0;
  localparam int c_PF = 1;
  localparam int c_ZF = 2;
  localparam int c_SF = 3;
  localparam int c_OF = 4;

  localparam logic [1:0] c_FOP_CLC  = 2'b00;
  localparam logic [1:0] c_FOP_STC  = 2'b01;
  localparam logic [1:0] c_FOP_CMC  = 2'b10;
  localparam logic [1:0] c_FOP_LOAD = 2'b11;

  localparam logic [PEND_W-1:0] c_MAX_PEND = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] c_ONE      = PEND_W'(1);

  logic [4:0]        r_status;
  logic [PEND_W-1:0] r_pend;
  logic              r_err;
  logic              r_resp_valid;
  logic              r_taken;

  logic              w_pend_zero;
  logic              w_issue_acc;
  logic              w_fop_acc;
  logic              w_cc_acc;
  logic              w_wb_err;
  logic [PEND_W-1:0] w_pend_nxt;
  logic [4:0]        w_f1;
  logic [4:0]        w_f2;
  logic              w_cc_base;
  logic              w_cc_taken;

  // Readiness comes from the registered counter only, never from valids.
  assign w_pend_zero = (r_pend == '0);
  assign issue_ready = (r_pend < c_MAX_PEND);
  assign fop_ready   = w_pend_zero;
  assign cc_ready    = w_pend_zero;

  assign w_issue_acc = issue_valid & issue_ready;
  assign w_fop_acc   = fop_valid & w_pend_zero;
  assign w_cc_acc    = cc_valid & w_pend_zero;
  assign w_wb_err    = wb_valid & ~w_issue_acc & w_pend_zero;

  always_comb begin
    w_pend_nxt = r_pend;
    case ({w_issue_acc, wb_valid})
      2'b10:   w_pend_nxt = r_pend + c_ONE;
      2'b01:   w_pend_nxt = w_pend_zero ? r_pend : (r_pend - c_ONE);
      default: w_pend_nxt = r_pend;
    endcase
  end

  assign w_f1 = wb_valid ? ((r_status & ~wb_mask) | (wb_status & wb_mask)) : r_status;

  always_comb begin
    w_f2 = w_f1;
    if (w_fop_acc) begin
      case (fop_code)
        c_FOP_CLC:  w_f2[c_CF] = 1'b0;
        c_FOP_STC:  w_f2[c_CF] = 1'b1;
        c_FOP_CMC:  w_f2[c_CF] = ~w_f1[c_CF];
        c_FOP_LOAD: w_f2       = fop_load;
        default:    w_f2       = w_f1;
      endcase
    end
  end

  // Odd condition codes are the negation of the even code below them.
  always_comb begin
    w_cc_base = 1'b0;
    case (cc_code[3:1])
      3'd0:    w_cc_base = w_f2[c_OF];
      3'd1:    w_cc_base = w_f2[c_CF];
      3'd2:    w_cc_base = w_f2[c_ZF];
      3'd3:    w_cc_base = w_f2[c_CF] | w_f2[c_ZF];
      3'd4:    w_cc_base = w_f2[c_SF];
      3'd5:    w_cc_base = w_f2[c_PF];
      3'd6:    w_cc_base = w_f2[c_SF] ^ w_f2[c_OF];
      3'd7:    w_cc_base = w_f2[c_ZF] | (w_f2[c_SF] ^ w_f2[c_OF]);
      default: w_cc_base = 1'b0;
    endcase
  end

  assign w_cc_taken = w_cc_base ^ cc_code[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status     <= '0;
      r_pend       <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_taken      <= 1'b0;
    end else begin
      r_status     <= w_f2;
      r_pend       <= w_pend_nxt;
      r_err        <= r_err | w_wb_err;
      r_resp_valid <= w_cc_acc;
      r_taken      <= w_cc_acc & w_cc_taken;
    end
  end

  assign status_out    = r_status;
  assign pending       = r_pend;
  assign proto_err     = r_err;
  assign cc_resp_valid = r_resp_valid;
  assign cc_taken      = r_taken;

endmodule
`default_nettype wire
